// File: rtl/st7789_spi_stream.sv
// st7789_spi_stream: ST7789 SPI bring-up (reset, SLPOUT, init ROM, address window) then RGB565 streaming.
// Define LCD_FRAME_SYNC_EN to resend the address window after every complete frame.
module st7789_spi_stream #(
    parameter int H_RES    = 240,
    parameter int V_RES    = 135,
    parameter int X_OFS    = 40,
    parameter int Y_OFS    = 53,
    parameter int SPI_DIV  = 1,
    parameter int RST_CYC  = 2700000,
    parameter int PREP_CYC = 5400000,
    parameter int WAKE_CYC = 3240000
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     lcd_resetn,
    output logic                     lcd_clk,
    output logic                     lcd_cs,
    output logic                     lcd_dc,
    output logic                     lcd_mosi,
    output logic                     pix_req,
    output logic [$clog2(H_RES)-1:0] pix_x,
    output logic [$clog2(V_RES)-1:0] pix_y,
    input  logic                     pix_valid,
    input  logic [15:0]              pix_data,
    output logic                     frame_start,
    output logic                     init_done
);
    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam int DW = SPI_DIV > 1 ? $clog2(SPI_DIV) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);
    localparam logic [DW-1:0] D_MAX = DW'(SPI_DIV - 1);
    localparam logic [31:0] RST_W = 32'(RST_CYC);
    localparam logic [31:0] PREP_W = 32'(PREP_CYC);
    localparam logic [31:0] WAKE_W = 32'(WAKE_CYC);
    localparam logic [15:0] XS = 16'(X_OFS);
    localparam logic [15:0] XE = 16'(X_OFS + H_RES - 1);
    localparam logic [15:0] YS = 16'(Y_OFS);
    localparam logic [15:0] YE = 16'(Y_OFS + V_RES - 1);
    localparam logic [0:10][8:0] WIN = {9'h02A, 1'b1, XS[15:8], 1'b1, XS[7:0], 1'b1, XE[15:8], 1'b1, XE[7:0],
                                        9'h02B, 1'b1, YS[15:8], 1'b1, YS[7:0], 1'b1, YE[15:8], 1'b1, YE[7:0],
                                        9'h02C};
    // {dc, byte}: dc=0 marks a command, dc=1 its parameter bytes
    localparam logic [0:58][8:0] ROM = {
        9'h036, 9'h170, 9'h03A, 9'h105,
        9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133,
        9'h0B7, 9'h135, 9'h0BB, 9'h119, 9'h0C0, 9'h12C,
        9'h0C2, 9'h101, 9'h0C3, 9'h112, 9'h0C4, 9'h120, 9'h0C6, 9'h10F,
        9'h0D0, 9'h1A4, 9'h1A1,
        9'h0E0, 9'h1D0, 9'h104, 9'h10D, 9'h111, 9'h113, 9'h12B, 9'h13F,
        9'h154, 9'h14C, 9'h118, 9'h10D, 9'h10B, 9'h11F, 9'h123,
        9'h0E1, 9'h1D0, 9'h104, 9'h10C, 9'h111, 9'h113, 9'h12C, 9'h13F,
        9'h144, 9'h151, 9'h12F, 9'h11F, 9'h11F, 9'h120, 9'h123,
        9'h021, 9'h029};

    typedef enum logic [2:0] {S_RESET, S_PREPARE, S_WAKE, S_SNOOZE, S_INIT, S_WINDOW, S_STREAM} state_t;
    state_t state, nxt;

    logic [31:0]   cnt;
    logic          busy, dc_r, ready, act, ld, hs, buf_full, lo_pend;
    logic [4:0]    ph;
    logic [DW-1:0] dcnt;
    logic [7:0]    sh, lo;
    logic [8:0]    ld_word;
    logic [15:0]   pbuf;
`ifdef LCD_FRAME_SYNC_EN
    logic          hold;
`endif

    // a slot is 18 phases of SPI_DIV cycles; the next byte may load in the last cycle of phase 17
    assign ready = !busy || (ph == 5'd17 && dcnt == D_MAX);
    assign act = busy && !ph[4];
    assign lcd_cs = !act;
    assign lcd_clk = act && ph[0];
    assign lcd_mosi = !act || sh[~ph[3:1]];
    assign lcd_dc = dc_r;
    assign hs = pix_req && pix_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_RESET;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_RESET:   if (cnt == RST_W - 32'd1) nxt = S_PREPARE;
            S_PREPARE: if (cnt + 32'd2 >= PREP_W) nxt = S_WAKE;
            S_WAKE:    if (ready) nxt = S_SNOOZE;
            S_SNOOZE:  if (cnt == WAKE_W - 32'd1) nxt = S_INIT;
            S_INIT:    if (ld && cnt == 32'd58) nxt = S_WINDOW;
            S_WINDOW:  if (ld && cnt == 32'd10) nxt = S_STREAM;
            S_STREAM: begin
`ifdef LCD_FRAME_SYNC_EN
                if (hold && !buf_full && !lo_pend) nxt = S_WINDOW;
`endif
            end
            default:   nxt = S_RESET;
        endcase
    end

    always_comb begin
        lcd_resetn = state != S_RESET;
        ld = ready && (state == S_WAKE || state == S_INIT || state == S_WINDOW ||
                       (state == S_STREAM && (lo_pend || buf_full)));
        ld_word = state == S_WAKE   ? 9'h011 :
                  state == S_INIT   ? ROM[cnt[5:0]] :
                  state == S_WINDOW ? WIN[cnt[3:0]] :
                  lo_pend           ? {1'b1, lo} : {1'b1, pbuf[15:8]};
`ifdef LCD_FRAME_SYNC_EN
        pix_req = state == S_STREAM && !buf_full && !hold;
`else
        pix_req = state == S_STREAM && !buf_full;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            busy <= 1'b0;
            ph <= '0;
            dcnt <= '0;
            sh <= '0;
            dc_r <= 1'b1;
            pbuf <= '0;
            buf_full <= 1'b0;
            lo <= '0;
            lo_pend <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            frame_start <= 1'b0;
            init_done <= 1'b0;
        end else begin
            cnt <= nxt != state ? '0 : (ld || (state != S_INIT && state != S_WINDOW)) ? cnt + 32'd1 : cnt;
            if (ld) begin
                busy <= 1'b1;
                ph <= '0;
                dcnt <= '0;
                {dc_r, sh} <= ld_word;
            end else if (busy) begin
                dcnt <= dcnt == D_MAX ? '0 : dcnt + 1'b1;
                if (dcnt == D_MAX) begin
                    ph <= ph + 5'd1;
                    busy <= ph != 5'd17;
                end
            end
            frame_start <= hs && pix_x == '0 && pix_y == '0;
            init_done <= init_done || nxt == S_STREAM;
            // taking the high byte frees the buffer so the next request overlaps shifting
            if (hs) begin
                pbuf <= pix_data;
                buf_full <= 1'b1;
                pix_x <= pix_x == X_MAX ? '0 : pix_x + 1'b1;
                if (pix_x == X_MAX) pix_y <= pix_y == Y_MAX ? '0 : pix_y + 1'b1;
            end else if (ld && state == S_STREAM && !lo_pend) begin
                buf_full <= 1'b0;
            end
            if (ld && state == S_STREAM) begin
                lo_pend <= !lo_pend;
                if (!lo_pend) lo <= pbuf[7:0];
            end
        end
    end

`ifdef LCD_FRAME_SYNC_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hold <= 1'b0;
        else if (hs && pix_x == X_MAX && pix_y == Y_MAX) hold <= 1'b1;
        else if (nxt == S_WINDOW) hold <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_st7789_spi_stream.sv
// tb_st7789_spi_stream: bench for st7789_spi_stream with a byte-level model of the expected SPI traffic.
// Honours LCD_FRAME_SYNC_EN by expecting window bytes after each full frame.
module tb_st7789_spi_stream;
    localparam int H = 4, V = 2, XO = 40, YO = 53, DIV = 2, RST = 27, PREP = 54, WK = 32;

    logic clk = 1'b0, resetn = 1'b0;
    logic lcd_resetn, lcd_clk, lcd_cs, lcd_dc, lcd_mosi, pix_req, frame_start, init_done;
    logic pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic [1:0] pix_x;
    logic [0:0] pix_y;

    int n_chk = 0, n_fail = 0, cyc = 0, k = 0, nb = 0;
    bit hs_prev = 0, fs_exp = 0, stalled = 0;
    logic [7:0] sr = '0;
    logic [8:0] got[$], exp_q[$];
    int falls[$];

    st7789_spi_stream #(.H_RES(H), .V_RES(V), .X_OFS(XO), .Y_OFS(YO), .SPI_DIV(DIV),
                        .RST_CYC(RST), .PREP_CYC(PREP), .WAKE_CYC(WK)) dut (
        .clk(clk), .resetn(resetn), .lcd_resetn(lcd_resetn), .lcd_clk(lcd_clk), .lcd_cs(lcd_cs),
        .lcd_dc(lcd_dc), .lcd_mosi(lcd_mosi), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_data(pix_data), .frame_start(frame_start), .init_done(init_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI decoder: sample mosi on each rising lcd_clk, abandon partial bytes when cs rises
    initial forever begin
        @(posedge lcd_clk or posedge lcd_cs);
        if (lcd_cs) nb = 0;
        else begin
            sr = {sr[6:0], lcd_mosi};
            nb = nb + 1;
            if (nb == 8) begin
                got.push_back({lcd_dc, sr});
                nb = 0;
            end
        end
    end

    initial forever begin
        @(negedge lcd_cs);
        falls.push_back(cyc);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push16(input logic [15:0] d);
        exp_q.push_back({1'b1, d[15:8]});
        exp_q.push_back({1'b1, d[7:0]});
    endtask

    task automatic push_win();
        exp_q.push_back(9'h02A);
        push16(16'(XO));
        push16(16'(XO + H - 1));
        exp_q.push_back(9'h02B);
        push16(16'(YO));
        push16(16'(YO + V - 1));
        exp_q.push_back(9'h02C);
    endtask

    task automatic chk_rst(input string tag);
        chk(tag, {lcd_resetn, lcd_cs, lcd_dc, lcd_clk, lcd_mosi, pix_req, pix_x, pix_y, frame_start, init_done},
            11'b0_1_1_0_1_0_00_0_0_0);
    endtask

    // one clock of upstream behaviour; a handshake is predicted from pix_req before the edge
    task automatic step(input bit v, input logic [15:0] d);
        @(negedge clk);
        chk("frame_start", frame_start, fs_exp);
        if (hs_prev) chk("req_drop", pix_req, 1'b0);
        pix_valid = v;
        pix_data = d;
        hs_prev = pix_req && v;
        fs_exp = 0;
        if (hs_prev) begin
            chk("pix_x", pix_x, k % H);
            chk("pix_y", pix_y, (k / H) % V);
            fs_exp = (k % (H * V)) == 0;
            push16(d);
            k++;
`ifdef LCD_FRAME_SYNC_EN
            if (k % (H * V) == 0) push_win();
`endif
        end
    endtask

    task automatic cmp_bytes(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic do_init();
        int c;
        got.delete();
        falls.delete();
        @(negedge clk);
        resetn = 1'b1;
        c = 0;
        while (!lcd_resetn && c < 1000) begin @(negedge clk); c++; end
        chk("rst_release", c, RST);
        c = 0;
        while (lcd_cs && c < 1000) begin @(negedge clk); c++; end
        chk("first_cs", c, PREP);
        chk("wake_dc", lcd_dc, 1'b0);
        c = 0;
        while (!init_done && c < 20000) begin @(negedge clk); c++; end
        chk("init_done", init_done, 1'b1);
        repeat (40 * DIV) @(negedge clk);
        chk("init_bytes", got.size(), 71);
        exp_q.delete();
        push_win();
        if (got.size() == 71) begin
            chk("slpout", got[0], 9'h011);
            chk("madctl", got[1], 9'h036);
            chk("madctl_arg", got[2], 9'h170);
            chk("colmod", got[3], 9'h03A);
            chk("colmod_arg", got[4], 9'h105);
            chk("invon", got[58], 9'h021);
            chk("dispon", got[59], 9'h029);
            for (int i = 0; i < 11; i++) chk($sformatf("win%0d", i), got[60 + i], exp_q[i]);
        end
        got.delete();
        falls.delete();
        exp_q.delete();
        k = 0;
        hs_prev = 0;
        fs_exp = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_rst("reset_values");
        do_init();

        chk("req_ready", pix_req, 1'b1);
        step(1'b1, 16'hF800);
        step(1'b0, 16'h0000);
        chk("x_after_first", pix_x, 1);
        for (int t = 0; t < 200 && got.size() < 2; t++) step(1'b0, 16'h0000);
        chk("first_bytes_seen", got.size() >= 2, 1'b1);
        if (got.size() >= 2) begin
            chk("first_hi", got[0], 9'h1F8);
            chk("first_lo", got[1], 9'h100);
        end
        if (falls.size() >= 2) chk("slot_len", falls[1] - falls[0], 18 * DIV);
        else chk("slot_falls", falls.size(), 2);

        for (int t = 0; t < 5000 && k < 2 * H * V + 3; t++) begin
            if (k == H + 1 && !stalled) begin
                stalled = 1;
                for (int s = 0; s < 100 * DIV; s++) begin
                    step(1'b0, 16'h0000);
                    if (s >= 80 * DIV) begin
                        chk("stall_cs", lcd_cs, 1'b1);
                        chk("stall_clk", lcd_clk, 1'b0);
                    end
                end
            end else step($urandom_range(3) != 0, 16'($urandom));
        end
        chk("handshakes", k, 2 * H * V + 3);
        repeat (800) step(1'b0, 16'h0000);
        cmp_bytes("stream");

        begin
            int n0, t;
            n0 = falls.size();
            t = 0;
            while (falls.size() == n0 && t < 500) begin step(1'b1, 16'($urandom)); t++; end
            chk("mid_reset_slot", falls.size() > n0, 1'b1);
            repeat (8 * DIV) @(posedge clk);
            #1;
            chk("mid_reset_bits", nb, 4);
            resetn = 1'b0;
            pix_valid = 1'b0;
            #1;
            chk_rst("async_reset");
        end
        repeat (3) @(negedge clk);
        do_init();
        for (int t = 0; t < 2000 && k < 3; t++) step($urandom_range(1) != 0, 16'($urandom));
        chk("restart_handshakes", k, 3);
        repeat (400) step(1'b0, 16'h0000);
        cmp_bytes("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
